// File: rtl/sevseg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sevseg_pkg
//  Description : Shared constants, types and the hex-to-segment decode table
//                for the four-digit seven-segment scan driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package sevseg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DATA_W     = 4 * NUM_DIGITS;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  // Segment order {g,f,e,d,c,b,a}, active-low: all ones turns every segment off.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // One displayable frame: four hex nibbles plus a decimal-point request per digit.
  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [NUM_DIGITS-1:0] dp;
  } disp_word_t;

  // Active-low segment pattern for one hex nibble (lower-case b and d).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_sevseg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_to_sevseg
//  Description : Purely combinational nibble to active-low segment decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_to_sevseg
  import sevseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup shared with anything else that imports the package.
  assign seg = hex_to_seg(nibble);

endmodule
`default_nettype wire

// File: rtl/sevseg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : sevseg_scan_driver
//  Description : Time-multiplexed four-digit seven-segment driver. Holds a
//                pending and an active display word; the active word only
//                changes at the digit 3 -> digit 0 wrap so a frame never
//                shows a mix of old and new digits. All outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module sevseg_scan_driver
  import sevseg_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int CNT_W    = 17
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic [DATA_W-1:0]     DATA,
  input  logic                  LOAD,
  input  logic [NUM_DIGITS-1:0] DP_IN,
  input  logic                  BLANK_LZ,
  input  logic                  EN,
  output logic [NUM_DIGITS-1:0] AN,
  output logic [6:0]            CA,
  output logic                  DP,
  output logic                  FRAME_TICK
);

  localparam logic [CNT_W-1:0] c_TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] c_IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_started;
  disp_word_t            r_pending;
  disp_word_t            r_active;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_ca;
  logic                  r_dp;
  logic                  r_frame_tick;

  logic                  w_tick;
  logic                  w_wrap;
  disp_word_t            w_load_word;
  logic [3:0]            w_nibble;
  logic [6:0]            w_seg;
  logic [NUM_DIGITS-1:0] w_lz;
  logic [NUM_DIGITS-1:0] w_an_sel;
  logic                  w_dp_req;
  logic                  w_blank_digit;
  logic [NUM_DIGITS-1:0] w_an_nxt;
  logic [6:0]            w_ca_nxt;
  logic                  w_dp_nxt;

  // The prescaler only advances while enabled, so a disabled scan freezes mid-slot.
  assign w_tick      = EN && (r_cnt == c_TICK_LAST);
  assign w_wrap      = w_tick && (r_idx == c_IDX_LAST);
  assign w_load_word = '{data: DATA, dp: DP_IN};

  // Refresh prescaler: one tick every TICK_DIV enabled cycles.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_cnt <= '0;
    end else if (EN) begin
      if (r_cnt == c_TICK_LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Digit index advances on each tick; the display stays dark until the first tick.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_idx     <= '0;
      r_started <= 1'b0;
    end else if (w_tick) begin
      r_idx     <= r_idx + 1'b1;
      r_started <= 1'b1;
    end
  end

  // Pending word captures every LOAD; the last LOAD before a frame boundary wins.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_pending <= '0;
    end else if (LOAD) begin
      r_pending <= w_load_word;
    end
  end

  // Active word swaps only at the frame boundary; a LOAD on that very cycle bypasses pending.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_active     <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_wrap;
      if (w_wrap) begin
        r_active <= LOAD ? w_load_word : r_pending;
      end
    end
  end

  // Select the nibble and decimal-point request for the digit being scanned.
  assign w_nibble = r_active.data[{r_idx, 2'b00} +: 4];
  assign w_dp_req = r_active.dp[r_idx];
  assign w_an_sel = ~(NUM_DIGITS'(1) << r_idx);

  hex_to_sevseg u_dec (
    .nibble (w_nibble),
    .seg    (w_seg)
  );

  // A digit is a leading zero when it and every more-significant nibble are zero.
  assign w_lz[0] = 1'b0;
  for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_lz
    assign w_lz[k] = (r_active.data[DATA_W-1:4*k] == '0);
  end

  assign w_blank_digit = BLANK_LZ && w_lz[r_idx];

  // Next output values: dark when disabled or before the first tick; a blanked
  // digit keeps its anode low only so a requested decimal point still shows.
  always_comb begin
    w_an_nxt = '1;
    w_ca_nxt = SEG_BLANK;
    w_dp_nxt = 1'b1;
    if (EN && r_started) begin
      w_dp_nxt = ~w_dp_req;
      if (!w_blank_digit) begin
        w_an_nxt = w_an_sel;
        w_ca_nxt = w_seg;
      end else if (w_dp_req) begin
        w_an_nxt = w_an_sel;
      end
    end
  end

  // Output registers isolate the pins from every input.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_an <= '1;
      r_ca <= SEG_BLANK;
      r_dp <= 1'b1;
    end else begin
      r_an <= w_an_nxt;
      r_ca <= w_ca_nxt;
      r_dp <= w_dp_nxt;
    end
  end

  assign AN         = r_an;
  assign CA         = r_ca;
  assign DP         = r_dp;
  assign FRAME_TICK = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_sevseg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sevseg_scan_driver
//  Description : Directed, table-driven bench for sevseg_scan_driver with
//                TICK_DIV=4. Edge numbers count rising edges after reset
//                release; outputs are sampled on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sevseg_scan_driver;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [15:0] DATA;
  logic        LOAD;
  logic [3:0]  DP_IN;
  logic        BLANK_LZ;
  logic        EN;
  logic [3:0]  AN;
  logic [6:0]  CA;
  logic        DP;
  logic        FRAME_TICK;

  int checks = 0;
  int errors = 0;
  int ec     = 0;

  typedef struct {
    int          e;
    logic        ld;
    logic [15:0] d;
    logic [3:0]  dpi;
    logic        blz;
    logic        en;
    logic [3:0]  an;
    logic [6:0]  ca;
    logic        dp;
    logic        ft;
  } vec_t;

  vec_t vq[$];

  sevseg_scan_driver #(.TICK_DIV(4), .CNT_W(3)) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .DATA       (DATA),
    .LOAD       (LOAD),
    .DP_IN      (DP_IN),
    .BLANK_LZ   (BLANK_LZ),
    .EN         (EN),
    .AN         (AN),
    .CA         (CA),
    .DP         (DP),
    .FRAME_TICK (FRAME_TICK)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string name, input logic [3:0] an, input logic [6:0] ca,
                     input logic dp, input logic ft);
    checks++;
    if (AN !== an || CA !== ca || DP !== dp || FRAME_TICK !== ft) begin
      errors++;
      $display("FAIL %s: got AN=%b CA=%b DP=%b FT=%b, expected AN=%b CA=%b DP=%b FT=%b",
               name, AN, CA, DP, FRAME_TICK, an, ca, dp, ft);
    end
  endtask

  // Advance to falling edge after rising edge number e; LOAD is a one-cycle strobe.
  task automatic goto(input int e);
    while (ec < e) begin
      @(negedge CLOCK);
      ec++;
      LOAD = 1'b0;
    end
  endtask

  initial begin
    int n_ft;

    //          e    ld  data     dpi      blz  en   AN       CA          DP  FT
    vq.push_back('{  0, 1, 16'hF0A1, 4'b0000, 0, 1, 4'b1111, 7'b1111111, 1, 0});
    vq.push_back('{  4, 0, 16'hF0A1, 4'b0000, 0, 1, 4'b1111, 7'b1111111, 1, 0});
    vq.push_back('{  5, 0, 16'hF0A1, 4'b0000, 0, 1, 4'b1101, 7'b1000000, 1, 0});
    vq.push_back('{ 16, 0, 16'hF0A1, 4'b0000, 0, 1, 4'b0111, 7'b1000000, 1, 1});
    vq.push_back('{ 17, 0, 16'hF0A1, 4'b0000, 0, 1, 4'b1110, 7'b1111001, 1, 0});
    vq.push_back('{ 21, 0, 16'hF0A1, 4'b0000, 0, 1, 4'b1101, 7'b0001000, 1, 0});
    vq.push_back('{ 25, 0, 16'hF0A1, 4'b0000, 0, 1, 4'b1011, 7'b1000000, 1, 0});
    vq.push_back('{ 29, 0, 16'hF0A1, 4'b0000, 0, 1, 4'b0111, 7'b0001110, 1, 0});
    vq.push_back('{ 32, 1, 16'h0005, 4'b0000, 1, 1, 4'b0111, 7'b0001110, 1, 1});
    vq.push_back('{ 33, 0, 16'h0005, 4'b0000, 1, 1, 4'b1110, 7'b1111001, 1, 0});
    vq.push_back('{ 49, 0, 16'h0005, 4'b0000, 1, 1, 4'b1110, 7'b0010010, 1, 0});
    vq.push_back('{ 53, 0, 16'h0005, 4'b0000, 1, 1, 4'b1111, 7'b1111111, 1, 0});
    vq.push_back('{ 57, 0, 16'h0005, 4'b0000, 1, 1, 4'b1111, 7'b1111111, 1, 0});
    vq.push_back('{ 61, 0, 16'h0005, 4'b0000, 0, 1, 4'b1111, 7'b1111111, 1, 0});
    vq.push_back('{ 62, 0, 16'h0005, 4'b0000, 0, 1, 4'b0111, 7'b1000000, 1, 0});
    vq.push_back('{ 65, 1, 16'h1111, 4'b0000, 0, 1, 4'b1110, 7'b0010010, 1, 0});
    vq.push_back('{ 69, 0, 16'h1111, 4'b0000, 0, 1, 4'b1101, 7'b1000000, 1, 0});
    vq.push_back('{ 77, 0, 16'h1111, 4'b0000, 0, 1, 4'b0111, 7'b1000000, 1, 0});
    vq.push_back('{ 81, 0, 16'h1111, 4'b0000, 0, 1, 4'b1110, 7'b1111001, 1, 0});
    vq.push_back('{ 85, 0, 16'h1111, 4'b0000, 0, 1, 4'b1101, 7'b1111001, 1, 0});
    vq.push_back('{ 95, 1, 16'h8E2C, 4'b0000, 0, 1, 4'b0111, 7'b1111001, 1, 0});
    vq.push_back('{ 97, 0, 16'h8E2C, 4'b0000, 0, 1, 4'b1110, 7'b1000110, 1, 0});
    vq.push_back('{101, 0, 16'h8E2C, 4'b0000, 0, 1, 4'b1101, 7'b0100100, 1, 0});
    vq.push_back('{105, 0, 16'h8E2C, 4'b0000, 0, 1, 4'b1011, 7'b0000110, 1, 0});
    vq.push_back('{109, 0, 16'h8E2C, 4'b0000, 0, 1, 4'b0111, 7'b0000000, 1, 0});
    vq.push_back('{113, 0, 16'h8E2C, 4'b0000, 0, 0, 4'b1110, 7'b1000110, 1, 0});
    vq.push_back('{114, 0, 16'h8E2C, 4'b0000, 0, 0, 4'b1111, 7'b1111111, 1, 0});
    vq.push_back('{123, 0, 16'h8E2C, 4'b0000, 0, 1, 4'b1111, 7'b1111111, 1, 0});
    vq.push_back('{124, 0, 16'h8E2C, 4'b0000, 0, 1, 4'b1110, 7'b1000110, 1, 0});
    vq.push_back('{126, 0, 16'h8E2C, 4'b0000, 0, 1, 4'b1110, 7'b1000110, 1, 0});
    vq.push_back('{127, 1, 16'h0000, 4'b0100, 1, 1, 4'b1101, 7'b0100100, 1, 0});
    vq.push_back('{128, 0, 16'h0000, 4'b0100, 1, 1, 4'b1101, 7'b0100100, 1, 0});
    vq.push_back('{138, 0, 16'h0000, 4'b0100, 1, 1, 4'b0111, 7'b0000000, 1, 1});
    vq.push_back('{139, 0, 16'h0000, 4'b0100, 1, 1, 4'b1110, 7'b1000000, 1, 0});
    vq.push_back('{143, 0, 16'h0000, 4'b0100, 1, 1, 4'b1111, 7'b1111111, 1, 0});
    vq.push_back('{147, 0, 16'h0000, 4'b0100, 1, 1, 4'b1011, 7'b1111111, 0, 0});
    vq.push_back('{151, 0, 16'h0000, 4'b0100, 0, 1, 4'b1111, 7'b1111111, 1, 0});

    RESET = 1'b1; DATA = '0; LOAD = 1'b0; DP_IN = '0; BLANK_LZ = 1'b0; EN = 1'b1;
    repeat (3) @(negedge CLOCK);
    chk("reset_state", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    RESET = 1'b0;
    ec    = 0;

    for (int i = 0; i < vq.size(); i++) begin
      goto(vq[i].e);
      chk($sformatf("vec%0d_edge%0d", i, vq[i].e), vq[i].an, vq[i].ca, vq[i].dp, vq[i].ft);
      LOAD = vq[i].ld; DATA = vq[i].d; DP_IN = vq[i].dpi; BLANK_LZ = vq[i].blz; EN = vq[i].en;
    end

    // Mid-frame reset: pending LOAD is lost and outputs go dark without a clock edge.
    LOAD = 1'b1; DATA = 16'hABCD; DP_IN = 4'b0000;
    goto(152);
    chk("pre_reset_lit", 4'b0111, 7'b1000000, 1'b1, 1'b0);
    #2 RESET = 1'b1;
    #1 chk("async_reset_dark", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    repeat (2) @(negedge CLOCK);
    RESET = 1'b0;
    ec    = 0;
    goto(4);
    chk("post_reset_no_tick", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    goto(5);
    chk("post_reset_first_digit", 4'b1101, 7'b1000000, 1'b1, 1'b0);
    n_ft = 0;
    while (ec < 32) begin
      goto(ec + 1);
      if (FRAME_TICK === 1'b1) n_ft++;
      if (ec == 17) chk("post_reset_pending_lost", 4'b1110, 7'b1000000, 1'b1, 1'b0);
    end
    checks++;
    if (n_ft != 2) begin
      errors++;
      $display("FAIL frame_tick_count: got %0d pulses in 32 cycles, expected 2", n_ft);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
